// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/func constants, ALU codes and the decode control bundle
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_reg_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_JAL  = 2'd1,
    JMP_J    = 2'd2,
    JMP_JR   = 2'd3
  } jmp_t;

  typedef enum logic [3:0] {
    ALU_INVALID = 4'd0,
    ALU_ADDU    = 4'd1,
    ALU_OR      = 4'd2,
    ALU_ADDIU   = 4'd3,
    ALU_SW      = 4'd4,
    ALU_LW      = 4'd5,
    ALU_BNE     = 4'd6,
    ALU_JAL     = 4'd7,
    ALU_J       = 4'd8,
    ALU_JR      = 4'd9,
    ALU_BEQ     = 4'd10,
    ALU_SLTU    = 4'd11,
    ALU_ANDI    = 4'd12,
    ALU_LUI     = 4'd13
  } alu_ctrl_t;

  typedef struct packed {
    logic      write_reg;
    logic      write_mem;
    logic      use_imm;
    logic      read_ram;
    dst_reg_t  dst_reg;
    jmp_t      jmp;
    logic      branch;
    alu_ctrl_t alu;
    logic      illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_ILLEGAL = '{
    write_reg: 1'b0, write_mem: 1'b0, use_imm: 1'b0, read_ram: 1'b0,
    dst_reg: DST_RT, jmp: JMP_NONE, branch: 1'b0, alu: ALU_INVALID, illegal: 1'b1
  };

  // Legal baseline: all control bits clear; callers set what the opcode needs.
  function automatic ctrl_t legal_ctrl(input alu_ctrl_t alu);
    ctrl_t c;
    c         = CTRL_ILLEGAL;
    c.illegal = 1'b0;
    c.alu     = alu;
    return c;
  endfunction

endpackage

// File: rtl/decode_table.sv
// rtl/decode_table.sv - combinational opcode/func to control bundle, register usage and immediate
// Optional encodings (beq, sltu, andi, lui) are enabled by DECODE_EXT_EN.
module decode_table
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [15:0] imm16,
  output ctrl_t       ctrl,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic [31:0] imm
);

  logic [5:0] func;
  assign func = imm16[5:0];

  always_comb begin
    ctrl    = CTRL_ILLEGAL;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    imm     = {{16{imm16[15]}}, imm16};
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin
            ctrl = legal_ctrl(ALU_ADDU);
            ctrl.write_reg = 1'b1;
            ctrl.dst_reg   = DST_RD;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
          end
          FN_OR: begin
            ctrl = legal_ctrl(ALU_OR);
            ctrl.write_reg = 1'b1;
            ctrl.dst_reg   = DST_RD;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
          end
          FN_JR: begin
            ctrl = legal_ctrl(ALU_JR);
            ctrl.dst_reg = DST_RD;
            ctrl.jmp     = JMP_JR;
            uses_rs = 1'b1;
          end
`ifdef DECODE_EXT_EN
          FN_SLTU: begin
            ctrl = legal_ctrl(ALU_SLTU);
            ctrl.write_reg = 1'b1;
            ctrl.dst_reg   = DST_RD;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      OP_ADDIU: begin
        ctrl = legal_ctrl(ALU_ADDIU);
        ctrl.write_reg = 1'b1;
        ctrl.use_imm   = 1'b1;
        uses_rs = 1'b1;
      end
      OP_SW: begin
        ctrl = legal_ctrl(ALU_SW);
        ctrl.write_mem = 1'b1;
        ctrl.use_imm   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_LW: begin
        ctrl = legal_ctrl(ALU_LW);
        ctrl.write_reg = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.read_ram  = 1'b1;
        uses_rs = 1'b1;
      end
      OP_BNE: begin
        ctrl = legal_ctrl(ALU_BNE);
        ctrl.branch = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_JAL: begin
        ctrl = legal_ctrl(ALU_JAL);
        ctrl.write_reg = 1'b1;
        ctrl.dst_reg   = DST_RA;
        ctrl.jmp       = JMP_JAL;
      end
      OP_J: begin
        ctrl = legal_ctrl(ALU_J);
        ctrl.dst_reg = DST_RA;
        ctrl.jmp     = JMP_J;
      end
`ifdef DECODE_EXT_EN
      OP_BEQ: begin
        ctrl = legal_ctrl(ALU_BEQ);
        ctrl.branch = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_ANDI: begin
        ctrl = legal_ctrl(ALU_ANDI);
        ctrl.write_reg = 1'b1;
        ctrl.use_imm   = 1'b1;
        uses_rs = 1'b1;
        imm     = {16'h0000, imm16};
      end
      OP_LUI: begin
        ctrl = legal_ctrl(ALU_LUI);
        ctrl.write_reg = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm     = {imm16, 16'h0000};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered handshaked decode stage with load-use bubble, flush and stall counter
// Extended encodings come from decode_table when DECODE_EXT_EN is defined.
module decode_stage
  import mips_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_write_reg,
  output logic                   out_write_mem,
  output logic                   out_use_imm,
  output logic                   out_read_ram,
  output logic                   out_branch,
  output logic [1:0]             out_dst_reg,
  output logic [1:0]             out_jmp,
  output logic [3:0]             out_alu_ctrl,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [31:0]            out_imm,
  output logic [PC_W-1:0]        out_jtarget,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ctrl_t            dec_ctrl;
  ctrl_t            out_ctrl_q;
  logic             dec_uses_rs;
  logic             dec_uses_rt;
  logic [31:0]      dec_imm;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [PC_W-29:0] jt_hi;
  logic             hazard;
  logic             accept;
  logic             bubble;

  decode_table u_decode_table (
    .opcode  (in_instr[31:26]),
    .imm16   (in_instr[15:0]),
    .ctrl    (dec_ctrl),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .imm     (dec_imm)
  );

  assign in_rs = in_instr[25:21];
  assign in_rt = in_instr[20:16];

  // Upper bits of pc+4: a carry reaches bit 28 only when pc[27:2] is all ones.
  assign jt_hi = in_pc[PC_W-1:28] + (PC_W-28)'(&in_pc[27:2]);

  assign hazard = out_valid && out_ctrl_q.read_ram && (out_rt != 5'd0) &&
                  ((dec_uses_rs && (in_rs == out_rt)) || (dec_uses_rt && (in_rt == out_rt)));
  assign in_ready = !flush && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign bubble   = in_valid && hazard && !flush && out_ready;

  assign out_write_reg = out_ctrl_q.write_reg;
  assign out_write_mem = out_ctrl_q.write_mem;
  assign out_use_imm   = out_ctrl_q.use_imm;
  assign out_read_ram  = out_ctrl_q.read_ram;
  assign out_branch    = out_ctrl_q.branch;
  assign out_dst_reg   = out_ctrl_q.dst_reg;
  assign out_jmp       = out_ctrl_q.jmp;
  assign out_alu_ctrl  = out_ctrl_q.alu;
  assign out_illegal   = out_ctrl_q.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_ctrl_q  <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_jtarget <= '0;
      out_pc      <= '0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_ctrl_q  <= dec_ctrl;
        out_rs      <= in_rs;
        out_rt      <= in_rt;
        out_rd      <= in_instr[15:11];
        out_imm     <= dec_imm;
        out_jtarget <= {jt_hi, in_instr[25:0], 2'b00};
        out_pc      <= in_pc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (bubble && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

endmodule
